// File: rtl/set_job_sched_if.sv
// Handshake bundle around the SET job scheduler: command stream in, SET engine port, result stream out.
// master is the scheduler's view; slave is the view of the producer/SET/consumer side.
interface set_job_sched_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [23:0]      cmd_central;
    logic [11:0]      cmd_radius;
    logic [1:0]       cmd_mode;
    logic [TAG_W-1:0] cmd_tag;

    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy;
    logic             set_valid;
    logic [7:0]       set_candidate;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;

    modport master (
        input  cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag,
        output cmd_ready,
        output set_en, set_central, set_radius, set_mode,
        input  set_busy, set_valid, set_candidate,
        output res_valid, res_candidate, res_tag,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_central, cmd_radius, cmd_mode, cmd_tag,
        input  cmd_ready,
        input  set_en, set_central, set_radius, set_mode,
        output set_busy, set_valid, set_candidate,
        input  res_valid, res_candidate, res_tag,
        output res_ready
    );
endinterface

// File: rtl/set_job_sched.sv
// Job scheduler feeding the SET circle-counting engine: command FIFO, launch/credit FSM, result FIFO.
// Optional watchdog on a stuck SET engine is built when SET_TIMEOUT_EN is defined.
module set_job_sched #(
    parameter int TAG_W     = 4,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    set_job_sched_if.master      bus,
    output logic [15:0]          jobs_done,
    output logic                 err
);
    localparam int CAW   = $clog2(CMD_DEPTH);
    localparam int RAW   = $clog2(RES_DEPTH);
    localparam int CMD_W = TAG_W + 38;
    localparam int RES_W = TAG_W + 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, next_state;
    logic             live, live_next;
    logic             launch, res_push;
    logic [TAG_W-1:0] cur_tag;

    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW:0]     cmd_wptr, cmd_rptr;
    logic             cmd_empty, cmd_full, cmd_push;
    logic [TAG_W-1:0] head_tag;
    logic [1:0]       head_mode;
    logic [11:0]      head_radius;
    logic [23:0]      head_central;

    logic [RES_W-1:0] res_mem [RES_DEPTH];
    logic [RAW:0]     res_wptr, res_rptr, res_count;
    logic             res_empty, res_pop;
    logic [RAW+1:0]   in_flight;
    logic             credit_ok;

    assign cmd_empty = (cmd_wptr == cmd_rptr);
    assign cmd_full  = (cmd_wptr[CAW] != cmd_rptr[CAW]) &&
                       (cmd_wptr[CAW-1:0] == cmd_rptr[CAW-1:0]);
    assign cmd_push  = bus.cmd_valid && !cmd_full;
    assign bus.cmd_ready = !cmd_full;
    assign {head_tag, head_mode, head_radius, head_central} = cmd_mem[cmd_rptr[CAW-1:0]];

    assign res_empty = (res_wptr == res_rptr);
    assign res_count = res_wptr - res_rptr;
    assign res_pop   = !res_empty && bus.res_ready;
    assign bus.res_valid = !res_empty;
    assign {bus.res_tag, bus.res_candidate} = res_mem[res_rptr[RAW-1:0]];

    // A live job always owns a result slot, since SET cannot be back-pressured.
    assign in_flight = {1'b0, res_count} + (RAW+2)'(live);
    assign credit_ok = in_flight < (RAW+2)'(RES_DEPTH);

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wptr[CAW-1:0]] <= {bus.cmd_tag, bus.cmd_mode, bus.cmd_radius, bus.cmd_central};
        if (res_push)
            res_mem[res_wptr[RAW-1:0]] <= {cur_tag, bus.set_candidate};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            res_wptr  <= '0;
            res_rptr  <= '0;
            jobs_done <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + 1'b1;
            if (launch)   cmd_rptr <= cmd_rptr + 1'b1;
            if (res_pop)  res_rptr <= res_rptr + 1'b1;
            if (res_push) begin
                res_wptr  <= res_wptr + 1'b1;
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            live            <= 1'b0;
            cur_tag         <= '0;
            bus.set_en      <= 1'b0;
            bus.set_central <= '0;
            bus.set_radius  <= '0;
            bus.set_mode    <= '0;
        end else begin
            state      <= next_state;
            live       <= live_next;
            bus.set_en <= launch && (state == IDLE);
            if (launch) begin
                bus.set_central <= head_central;
                bus.set_radius  <= head_radius;
                bus.set_mode    <= head_mode;
                cur_tag         <= head_tag;
            end
        end
    end

    // Once started, SET restarts itself after every valid; when nothing is queued it repeats a phantom job.
    always_comb begin
        next_state = state;
        live_next  = live;
        launch     = 1'b0;
        res_push   = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && credit_ok) begin
                    launch     = 1'b1;
                    live_next  = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bus.set_valid) begin
                    res_push = live;
                    if (!cmd_empty && credit_ok) begin
                        launch    = 1'b1;
                        live_next = 1'b1;
                    end else begin
                        live_next = 1'b0;
                    end
                end
            end
        endcase
    end

`ifdef SET_TIMEOUT_EN
    localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT);
    logic [9:0] wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
            err  <= 1'b0;
        end else if (bus.set_en || bus.set_valid) begin
            wdog <= '0;
        end else if (state == RUN && wdog != TO_LIMIT) begin
            wdog <= wdog + 10'd1;
            if (wdog + 10'd1 == TO_LIMIT)
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_set_job_sched.sv
// Bench for set_job_sched: behavioural SET engine with auto-restart, table of jobs with hand-computed
// candidate counts, and a tag/candidate scoreboard checked whenever a result is consumed.
module tb_set_job_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] jobs_done;
    logic        err;

    set_job_sched_if #(.TAG_W(4)) bus ();

    set_job_sched #(.TAG_W(4), .CMD_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(50)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .jobs_done (jobs_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
        logic [3:0]  tag;
        logic [7:0]  cand;
    } vec_t;

    vec_t        vecs [13];
    logic [11:0] sb [$];
    int          pass_count = 0;
    int          total_count = 0;
    int          en_count = 0;
    int          reload_violations = 0;
    logic        stall = 1'b0;

    function automatic bit inCircle(input int x, input int y, input int cx, input int cy, input int r);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= r * r;
    endfunction

    function automatic logic [7:0] countSet(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = 0;
        bit a, b, k;
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                a = inCircle(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
                b = inCircle(x, y, int'(c[15:12]), int'(c[11:8]),  int'(r[7:4]));
                k = inCircle(x, y, int'(c[7:4]),   int'(c[3:0]),   int'(r[3:0]));
                case (m)
                    2'd0: n += int'(a);
                    2'd1: n += int'(a && b);
                    2'd2: n += int'(a ^ b);
                    2'd3: n += int'((int'(a) + int'(b) + int'(k)) == 2);
                endcase
            end
        end
        return 8'(n);
    endfunction

    // SET model: reads inputs one cycle after en, then again two cycles after every valid pulse.
    int         rd_cnt, run_cnt;
    logic [7:0] m_cand;
    always @(posedge clk) begin
        if (rst) begin
            bus.set_valid     <= 1'b0;
            bus.set_busy      <= 1'b0;
            bus.set_candidate <= 8'd0;
            rd_cnt            <= 0;
            run_cnt           <= 0;
            m_cand            <= 8'd0;
        end else begin
            bus.set_valid <= 1'b0;
            if (bus.set_en)
                rd_cnt <= 1;
            else if (rd_cnt != 0)
                rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1) begin
                m_cand       <= countSet(bus.set_central, bus.set_radius, bus.set_mode);
                run_cnt      <= 8 + 4 * int'(bus.set_mode);
                bus.set_busy <= 1'b1;
            end else if (run_cnt != 0 && !stall) begin
                run_cnt <= run_cnt - 1;
                if (run_cnt == 1) begin
                    bus.set_valid     <= 1'b1;
                    bus.set_candidate <= m_cand;
                    bus.set_busy      <= 1'b0;
                    rd_cnt            <= 3;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Result monitor, set_en counter and set_* stability watcher, all sampled mid-cycle.
    logic [37:0] prev_set = '0;
    logic        prev_valid = 1'b0;
    logic        prev_rst = 1'b1;
    logic [11:0] exp_res;
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", {24'd0, bus.res_tag, bus.res_candidate}, 32'd0);
            end else begin
                exp_res = sb.pop_front();
                checkOutput("res_tag", 32'(bus.res_tag), 32'(exp_res[11:8]));
                checkOutput("res_candidate", 32'(bus.res_candidate), 32'(exp_res[7:0]));
            end
        end
        if (!rst && bus.set_en)
            en_count++;
        if (!rst && !prev_rst && !prev_valid && !bus.set_en &&
            {bus.set_central, bus.set_radius, bus.set_mode} != prev_set)
            reload_violations++;
        prev_set   = {bus.set_central, bus.set_radius, bus.set_mode};
        prev_valid = bus.set_valid;
        prev_rst   = rst;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit done = 1'b0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_central = v.central;
        bus.cmd_radius  = v.radius;
        bus.cmd_mode    = v.mode;
        bus.cmd_tag     = v.tag;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                sb.push_back({v.tag, v.cand});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        if (!done)
            checkOutput("cmd_push_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.res_valid)
                done = 1'b1;
        end
        if (!done)
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int base;
        int en0;
        bit found;

        vecs[0]  = '{24'h444444, 12'h300, 2'd0, 4'd1,  8'd29};
        vecs[1]  = '{24'h444444, 12'h330, 2'd1, 4'd2,  8'd29};
        vecs[2]  = '{24'h444444, 12'h330, 2'd2, 4'd3,  8'd0};
        vecs[3]  = '{24'h444444, 12'h330, 2'd3, 4'd4,  8'd28};
        vecs[4]  = '{24'h444444, 12'h000, 2'd0, 4'd8,  8'd1};
        vecs[5]  = '{24'h444444, 12'h100, 2'd0, 4'd9,  8'd5};
        vecs[6]  = '{24'h444444, 12'h200, 2'd0, 4'd10, 8'd13};
        vecs[7]  = '{24'h444444, 12'h300, 2'd0, 4'd11, 8'd29};
        vecs[8]  = '{24'h444444, 12'h100, 2'd0, 4'd12, 8'd5};
        vecs[9]  = '{24'h444444, 12'h000, 2'd0, 4'd13, 8'd1};
        vecs[10] = '{24'h110000, 12'h100, 2'd0, 4'd7,  8'd3};
        vecs[11] = '{24'h444444, 12'h330, 2'd3, 4'd14, 8'd28};
        vecs[12] = '{24'h444444, 12'h200, 2'd0, 4'd15, 8'd13};

        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_central = '0;
        bus.cmd_radius  = '0;
        bus.cmd_mode    = '0;
        bus.cmd_tag     = '0;
        bus.res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("reset_set_en", 32'(bus.set_en), 32'd0);
        checkOutput("reset_set_data", {bus.set_central, bus.set_radius[7:0]}, 32'd0);
        checkOutput("reset_set_mode", 32'(bus.set_mode), 32'd0);
        checkOutput("reset_jobs_done", 32'(jobs_done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] single job from IDLE");
        applyStimulus(vecs[0]);
        waitDrain(500);
        @(negedge clk);
        checkOutput("single_en_pulses", 32'(en_count), 32'd1);
        checkOutput("single_jobs_done", 32'(jobs_done), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back jobs, modes 1..3");
        for (int i = 1; i <= 3; i++)
            applyStimulus(vecs[i]);
        waitDrain(1000);
        @(negedge clk);
        checkOutput("b2b_jobs_done", 32'(jobs_done), 32'd4);
        checkOutput("b2b_en_pulses", 32'(en_count), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] result back-pressure with six jobs");
        base = int'(jobs_done);
        bus.res_ready = 1'b0;
        for (int i = 4; i <= 9; i++)
            applyStimulus(vecs[i]);
        waitCycles(400);
        @(negedge clk);
        checkOutput("bp_live_launched", 32'(int'(jobs_done) - base), 32'd4);
        checkOutput("bp_res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        waitDrain(1000);
        @(negedge clk);
        checkOutput("bp_jobs_done", 32'(int'(jobs_done) - base), 32'd6);
        @(posedge clk);
        #1;

        $display("[TB] idle gap with phantom repeats");
        base = int'(jobs_done);
        waitCycles(2000);
        @(negedge clk);
        checkOutput("gap_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("gap_jobs_done", 32'(jobs_done), 32'(base));
        @(posedge clk);
        #1;
        applyStimulus(vecs[10]);
        waitDrain(500);
        @(negedge clk);
        checkOutput("gap_tag7_jobs", 32'(int'(jobs_done) - base), 32'd1);
        checkOutput("gap_en_pulses", 32'(en_count), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] reset in the middle of a mode-3 job");
        applyStimulus(vecs[11]);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.set_mode == 2'd3 && bus.set_busy)
                found = 1'b1;
        end
        checkOutput("mode3_started", 32'(found), 32'd1);
        waitCycles(5);
        rst = 1'b1;
        sb.delete();
        waitCycles(2);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("midrst_jobs_done", 32'(jobs_done), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        en0 = en_count;
        @(posedge clk);
        #1;
        applyStimulus(vecs[12]);
        waitDrain(500);
        @(negedge clk);
        checkOutput("post_rst_en_pulse", 32'(en_count - en0), 32'd1);
        checkOutput("post_rst_jobs_done", 32'(jobs_done), 32'd1);
        checkOutput("reload_timing", 32'(reload_violations), 32'd0);
        @(posedge clk);
        #1;

`ifdef SET_TIMEOUT_EN
        $display("[TB] watchdog with SET stalled");
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        stall = 1'b1;
        applyStimulus(vecs[12]);
        waitCycles(40);
        @(negedge clk);
        checkOutput("wdog_early_err", 32'(err), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (err)
                found = 1'b1;
        end
        checkOutput("wdog_err_set", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        waitCycles(100);
        @(negedge clk);
        checkOutput("wdog_err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        waitCycles(2);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        checkOutput("wdog_err_cleared", 32'(err), 32'd0);
`else
        @(negedge clk);
        checkOutput("err_tied_low", 32'(err), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
